// File: rtl/data_store_fifo.sv
// rtl/data_store_fifo.sv - committed-store buffer draining byte/half/word stores to memory
module data_store_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              datafifo_addr_in,
    input  logic [31:0]              datafifo_val_in,
    input  logic [1:0]               datafifo_size_in,
    input  logic                     datafifo_valid_in,
    output logic                     datafifo_full,
    output logic [31:0]              mem_wr_addr,
    output logic [31:0]              mem_wr_data,
    output logic [3:0]               mem_wr_strb,
    output logic                     mem_wr_valid,
    input  logic                     mem_wr_ready,
    input  logic                     mem_wr_access_fault,
    output logic                     store_fault_valid,
    output logic [31:0]              store_fault_addr,
    input  logic [31:0]              lookup_addr,
    output logic                     lookup_hit,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [31:0] addr_mem [DEPTH];
    logic [31:0] val_mem  [DEPTH];
    logic [1:0]  size_mem [DEPTH];

    logic [PW-1:0] head, tail;
    logic          push, pop;
    logic [31:0]   h_addr, h_val;
    logic [1:0]    h_size;
    logic          unused_lookup_low;

    assign unused_lookup_low = ^lookup_addr[1:0];

    // Status comes from the registered count only, keeping full/empty off the input paths.
    assign datafifo_full = (count == FULL_CNT);
    assign empty         = (count == '0);
    assign mem_wr_valid  = !empty;
    assign push          = datafifo_valid_in && !datafifo_full;
    assign pop           = mem_wr_valid && mem_wr_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= datafifo_addr_in;
            val_mem[tail]  <= datafifo_val_in;
            size_mem[tail] <= datafifo_size_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push) tail <= tail + PTR_ONE;
            if (pop)  head <= head + PTR_ONE;
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            if (datafifo_valid_in && datafifo_full)
                overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            store_fault_valid <= 1'b0;
            store_fault_addr  <= '0;
        end else begin
            store_fault_valid <= pop && mem_wr_access_fault;
            if (pop && mem_wr_access_fault)
                store_fault_addr <= h_addr;
        end
    end

    assign h_addr = addr_mem[head];
    assign h_val  = val_mem[head];
    assign h_size = size_mem[head];
    assign mem_wr_addr = {h_addr[31:2], 2'b00};

    // Lane steering: narrow stores are replicated so memory picks lanes by strobe alone.
    always_comb begin
        mem_wr_strb = 4'b0000;
        mem_wr_data = h_val;
        case (h_size)
            2'd0: begin
                mem_wr_strb = 4'b0001 << h_addr[1:0];
                mem_wr_data = {4{h_val[7:0]}};
            end
            2'd1: begin
                mem_wr_strb = 4'b0011 << {h_addr[1], 1'b0};
                mem_wr_data = {2{h_val[15:0]}};
            end
            2'd2: mem_wr_strb = 4'b1111;
            default: mem_wr_strb = 4'b0000;
        endcase
    end

    // An entry is occupied when its distance from head is below count.
    always_comb begin
        logic [PW-1:0] off;
        lookup_hit = 1'b0;
        off        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head;
            if (({1'b0, off} < count) && (addr_mem[i][31:2] == lookup_addr[31:2]))
                lookup_hit = 1'b1;
        end
    end
endmodule

// File: tb/tb_data_store_fifo.sv
// tb/tb_data_store_fifo.sv - randomized and directed bench against a queue model
module tb_data_store_fifo;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] datafifo_addr_in, datafifo_val_in;
    logic [1:0]  datafifo_size_in;
    logic        datafifo_valid_in, datafifo_full;
    logic [31:0] mem_wr_addr, mem_wr_data;
    logic [3:0]  mem_wr_strb;
    logic        mem_wr_valid, mem_wr_ready, mem_wr_access_fault;
    logic        store_fault_valid;
    logic [31:0] store_fault_addr, lookup_addr;
    logic        lookup_hit, empty, overflow_err;
    logic [$clog2(DEPTH):0] count;

    data_store_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .datafifo_addr_in(datafifo_addr_in), .datafifo_val_in(datafifo_val_in),
        .datafifo_size_in(datafifo_size_in), .datafifo_valid_in(datafifo_valid_in),
        .datafifo_full(datafifo_full),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_access_fault(mem_wr_access_fault),
        .store_fault_valid(store_fault_valid), .store_fault_addr(store_fault_addr),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
        .empty(empty), .count(count), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] val;
        logic [1:0]  size;
    } ent_t;

    ent_t        q[$];
    logic        m_ovf, m_fv;
    logic [31:0] m_fa;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_strb(input ent_t e);
        case (e.size)
            2'd0:    return 4'(1 << (e.addr % 4));
            2'd1:    return 4'(3 << (e.addr & 2));
            2'd2:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_data(input ent_t e);
        case (e.size)
            2'd0:    return {24'd0, e.val[7:0]} * 32'h01010101;
            2'd1:    return {16'd0, e.val[15:0]} * 32'h00010001;
            default: return e.val;
        endcase
    endfunction

    task automatic cmp_model();
        logic hit;
        hit = 1'b0;
        foreach (q[i]) if ((q[i].addr >> 2) == (lookup_addr >> 2)) hit = 1'b1;
        check("empty", empty, q.size() == 0);
        check("count", count, q.size());
        check("full", datafifo_full, q.size() == DEPTH);
        check("wr_valid", mem_wr_valid, q.size() != 0);
        check("overflow", overflow_err, m_ovf);
        check("fault_valid", store_fault_valid, m_fv);
        check("fault_addr", store_fault_addr, m_fa);
        check("lookup_hit", lookup_hit, hit);
        if (q.size() != 0) begin
            check("wr_addr", mem_wr_addr, q[0].addr & ~32'd3);
            check("wr_strb", mem_wr_strb, exp_strb(q[0]));
            check("wr_data", mem_wr_data, exp_data(q[0]));
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic rdy, input logic flt,
                         input logic [31:0] lk);
        datafifo_valid_in   = v;
        datafifo_addr_in    = a;
        datafifo_val_in     = d;
        datafifo_size_in    = s;
        mem_wr_ready        = rdy;
        mem_wr_access_fault = flt;
        lookup_addr         = lk;
        #1;
        cmp_model();
    endtask

    task automatic tick();
        bit   do_pop, do_push;
        ent_t e;
        @(posedge clk);
        do_pop  = (q.size() != 0) && mem_wr_ready;
        do_push = datafifo_valid_in && (q.size() < DEPTH);
        if (datafifo_valid_in && q.size() == DEPTH) m_ovf = 1'b1;
        m_fv = do_pop && mem_wr_access_fault;
        if (do_pop && mem_wr_access_fault) m_fa = q[0].addr;
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            e.addr = datafifo_addr_in;
            e.val  = datafifo_val_in;
            e.size = datafifo_size_in;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        #2;
        datafifo_valid_in = 1'b0;
        mem_wr_ready      = 1'b0;
        reset             = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_fv  = 1'b0;
        m_fa  = '0;
        check("rst_empty", empty, 1);
        check("rst_wr_valid", mem_wr_valid, 0);
        cmp_model();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        m_ovf = 1'b0;
        m_fv  = 1'b0;
        m_fa  = '0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("reset_full", datafifo_full, 0);
        check("reset_count", count, 0);
        check("reset_hit", lookup_hit, 0);
        cmp_model();
        reset = 1'b1;

        // byte store lane replication and one-cycle latency
        drive(1, 32'h1003, 32'hAB, 2'd0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        check("byte_valid", mem_wr_valid, 1);
        check("byte_addr", mem_wr_addr, 32'h1000);
        check("byte_strb", mem_wr_strb, 4'b1000);
        check("byte_data", mem_wr_data, 32'hABABABAB);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        check("byte_drained", empty, 1);

        // fill, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h10 + 4 * i, 32'hC0DE0000 + i, 2'd2, 0, 0, 0); tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("fill_full", datafifo_full, 1);
        check("fill_count", count, 4);
        drive(1, 32'h99, 32'hDEAD, 2'd2, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("ovf_set", overflow_err, 1);
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            check("drain_addr", mem_wr_addr, 32'h10 + 4 * i);
            check("drain_data", mem_wr_data, 32'hC0DE0000 + i);
            tick();
        end

        // full: push with simultaneous pop is rejected
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h40 + 4 * i, i, 2'd2, 0, 0, 0); tick();
        end
        drive(1, 32'h50, 32'h55, 2'd2, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("pushpop_count", count, 3);

        // half store with access fault
        apply_reset();
        drive(1, 32'h2002, 32'h1234, 2'd1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 1, 0);
        check("half_strb", mem_wr_strb, 4'b1100);
        check("half_data", mem_wr_data, 32'h12341234);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("fault_pulse", store_fault_valid, 1);
        check("fault_addr_val", store_fault_addr, 32'h2002);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("fault_one_cycle", store_fault_valid, 0);

        // load hazard lookup
        drive(1, 32'h3004, 32'h77, 2'd2, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 32'h3007);
        check("lookup_same_word", lookup_hit, 1);
        drive(0, 0, 0, 0, 0, 0, 32'h3008);
        check("lookup_next_word", lookup_hit, 0);
        drive(0, 0, 0, 0, 1, 0, 32'h3007);
        check("lookup_while_pop", lookup_hit, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h3007);
        check("lookup_after_pop", lookup_hit, 0);
        drive(1, 32'h3004, 32'h1, 2'd2, 0, 0, 32'h3004);
        check("lookup_push_same_cycle", lookup_hit, 0);
        tick();

        // pointer wrap then reset during a stall
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'h400 + 4 * i, i, 2'd2, 1, 0, 0); tick();
        end
        drive(1, 32'h500, 32'h5, 2'd0, 0, 0, 0); tick();
        drive(1, 32'h504, 32'h6, 2'd1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("wrap_count", count, 3);
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            check("post_rst_idle", mem_wr_valid, 0);
            tick();
        end

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            logic rdy;
            if ((c / 100) % 2 == 0) rdy = ($urandom % 4) == 0;
            else                    rdy = ($urandom % 4) != 0;
            drive(($urandom % 3) != 0, 32'h100 + $urandom_range(0, 63), $urandom,
                  2'($urandom % 4), rdy, ($urandom % 4) == 0,
                  32'h100 + $urandom_range(0, 63));
            if ($urandom % 250 == 0) apply_reset();
            else tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_store_fifo.md
DATA_STORE_FIFO -- requirements
Module: data_store_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, store-buffer entry count; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port datafifo_addr_in  input  32  store byte address from commit.
REQ-005 SHALL have port datafifo_val_in  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-006 SHALL have port datafifo_size_in  input  2  0=byte, 1=half, 2=word, 3=reserved.
REQ-007 SHALL have port datafifo_valid_in  input  1  push request.
REQ-008 SHALL have port datafifo_full  output  1  no free entry.
REQ-009 SHALL have ports mem_wr_addr  output  32, mem_wr_data  output  32, mem_wr_strb  output  4  head-entry write to memory.
REQ-010 SHALL have ports mem_wr_valid  output  1 and mem_wr_ready  input  1  write handshake.
REQ-011 SHALL have port mem_wr_access_fault  input  1  fault response, sampled with mem_wr_ready.
REQ-012 SHALL have ports store_fault_valid  output  1 and store_fault_addr  output  32  faulting store report.
REQ-013 SHALL have ports lookup_addr  input  32 and lookup_hit  output  1  load hazard check.
REQ-014 SHALL have ports empty  output  1, count  output  $clog2(DEPTH)+1, overflow_err  output  1.

Function
REQ-015 SHALL accept a push when datafifo_valid_in=1 and datafifo_full=0, writing the entry at the tail pointer at the clock edge.
REQ-016 SHALL drop a push while datafifo_full=1 and set overflow_err, sticky until reset.
REQ-017 SHALL derive datafifo_full (count==DEPTH) and empty (count==0) from registered count only; no combinational path from datafifo_valid_in or mem_wr_ready.
REQ-018 SHALL drive mem_wr_valid=!empty, with mem_wr_addr/data/strb taken from the head entry; payload stable while mem_wr_valid=1 and mem_wr_ready=0.
REQ-019 SHALL pop the head on mem_wr_valid && mem_wr_ready; one pop per cycle maximum.
REQ-020 SHALL on simultaneous accepted push and pop leave count unchanged; when full, push in the same cycle as a pop is still rejected (REQ-016).
REQ-021 SHALL wrap head/tail pointers modulo DEPTH.
REQ-022 SHALL drive mem_wr_addr = {addr[31:2],2'b00}.
REQ-023 SHALL form strb: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<{addr[1],1'b0}; word -> 4'b1111; reserved -> 4'b0000.
REQ-024 SHALL replicate data into lanes: byte -> {4{val[7:0]}}; half -> {2{val[15:0]}}; word/reserved -> val.
REQ-025 SHALL pop a reserved-size entry through the normal handshake (strb 0).
REQ-026 SHALL on a pop with mem_wr_access_fault=1 assert store_fault_valid for exactly one cycle on the following cycle, with store_fault_addr = original byte address; entry is still popped.
REQ-027 SHALL assert lookup_hit combinationally when any occupied entry has addr[31:2]==lookup_addr[31:2]; an entry being popped this cycle still counts; a push this cycle does not.
REQ-028 SHALL latency: a push into an empty FIFO presents mem_wr_valid=1 on the next cycle.

Reset
REQ-029 SHALL on reset=0 asynchronously clear pointers, count, overflow_err, store_fault_valid; outputs: datafifo_full=0, empty=1, count=0, mem_wr_valid=0, lookup_hit=0, store_fault_addr=0.
REQ-030 SHALL discard all entries on reset asserted mid-transfer; no write issued after reset deasserts until a new push.
REQ-031 SHALL not require entry storage to be reset.

Verification
REQ-032 SHALL cover: push byte addr 0x1003 val 0xAB, ready=1 -> next cycle mem_wr_addr=0x1000, strb=4'b1000, data=0xABABABAB, then empty=1.
REQ-033 SHALL cover: ready=0, push 4 words (DEPTH=4) -> full=1, count=4; 5th push -> dropped, overflow_err=1; ready=1 -> 4 writes in push order.
REQ-034 SHALL cover: full FIFO, push and pop same cycle -> push rejected, count=3.
REQ-035 SHALL cover: half store addr 0x2002 val 0x1234 with fault=1 at handshake -> strb=4'b1100, data=0x12341234, store_fault_valid one cycle with addr 0x2002.
REQ-036 SHALL cover: entry addr 0x3004 queued, lookup_addr 0x3007 -> hit=1; lookup 0x3008 -> hit=0; after pop -> hit=0.
REQ-037 SHALL cover: 6 pushes/pops through DEPTH=4 (pointer wrap) then reset mid-stall -> empty=1, mem_wr_valid=0 immediately.
